inference_result_logger: RTL and testbench

INFERENCE_RESULT_LOGGER -- requirements
Module: inference_result_logger

---
 rtl/inference_result_logger.sv | 194 +++++++++++++++++++
 tb/tb_inference_result_logger.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_result_logger.sv
// inference_result_logger
//   Captures one result word per rising edge of inference_done into a small
//   FIFO and exposes it to the SoC over a minimal AXI-lite register window.
//   Each result word is {seq[7:0], mode_select, noise_applied, predicted_class}.
//
// Ports
//   clk, resetn          : single clock, asynchronous active-low reset
//   predicted_class[3:0] : class from the privacy output stage
//   inference_done       : completion flag (level or pulse, edge detected)
//   mode_select          : 0 = MNIST, 1 = CIFAR10
//   noise_applied        : DP noise was injected for this result
//   axi_aw*/axi_w*       : write address/data, accepted when both valid
//   axi_ar*              : read request
//   axi_rdata/axi_rvalid : registered read response, one cycle after request
//   irq                  : level interrupt (threshold reached or overflow)
//
// Register map
//   0x0 POP    (R)   {valid, 17'b0, entry[13:0]}, pops when non-empty
//   0x4 STATUS (R)   [4:0] count, [8] empty, [9] full, [10] overflow,
//                    [23:16] drop_cnt
//   0x8 CTRL   (R/W) [0] irq_en, [7:4] threshold (0 is stored as 1)
//   0xC CLEAR  (W)   [0] flush FIFO, [1] clear overflow and drop_cnt

module inference_result_logger #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  predicted_class,
  input  logic        inference_done,
  input  logic        mode_select,
  input  logic        noise_applied,
  input  logic [3:0]  axi_awaddr,
  input  logic        axi_awvalid,
  input  logic [31:0] axi_wdata,
  input  logic        axi_wvalid,
  input  logic [3:0]  axi_araddr,
  input  logic        axi_arvalid,
  output logic [31:0] axi_rdata,
  output logic        axi_rvalid,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic              done_q;
  logic [7:0]        seq;
  logic              push_pending;
  logic [13:0]       push_entry;
  logic [13:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              irq_en;
  logic [3:0]        threshold;
  logic [31:0]       rd_data_next;

  logic              cap_event;
  logic              wr_fire;
  logic              ctrl_wr;
  logic              clr_wr;
  logic              flush;
  logic              clr_ovf;
  logic              empty;
  logic              full;
  logic              pop_req;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;
  logic [4:0]        count5;
  logic              unused_wdata;

  assign cap_event    = inference_done & ~done_q;
  assign wr_fire      = axi_awvalid & axi_wvalid;
  assign ctrl_wr      = wr_fire & (axi_awaddr == 4'h8);
  assign clr_wr       = wr_fire & (axi_awaddr == 4'hC);
  assign flush        = clr_wr & axi_wdata[0];
  assign clr_ovf      = clr_wr & axi_wdata[1];
  assign empty        = (count == '0);
  assign full         = (count == FULL_COUNT);
  assign pop_req      = axi_arvalid & (axi_araddr == 4'h0) & ~empty;
  assign count5       = 5'(count);
  assign unused_wdata = ^{axi_wdata[31:8], axi_wdata[3:2]};

  // A flush wins over everything; a pop frees the slot a same-cycle push
  // needs, so a push into a full FIFO only drops when nothing is popped.
  assign do_pop  = pop_req & ~flush;
  assign do_push = push_pending & ~flush & (~full | do_pop);
  assign do_drop = push_pending & ~flush & full & ~do_pop;

  // Edge detect on inference_done and stage the entry for a push next cycle.
  // The sequence number advances on every event, even if the entry is later
  // dropped or flushed, so software can see gaps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q       <= 1'b0;
      seq          <= 8'd0;
      push_pending <= 1'b0;
      push_entry   <= 14'd0;
    end else begin
      done_q       <= inference_done;
      push_pending <= cap_event;
      if (cap_event) begin
        push_entry <= {seq, mode_select, noise_applied, predicted_class};
        seq        <= seq + 8'd1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Sticky overflow and saturating drop counter. A drop in the same cycle
  // as a clear is still recorded, so no lost entry goes unreported.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (do_drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  // Control register; a zero threshold would make irq permanently true,
  // so it is coerced to 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en    <= 1'b0;
      threshold <= 4'd1;
    end else if (ctrl_wr) begin
      irq_en    <= axi_wdata[0];
      threshold <= (axi_wdata[7:4] == 4'h0) ? 4'h1 : axi_wdata[7:4];
    end
  end

  // Read data mux, evaluated on the state before any same-cycle update.
  always_comb begin
    rd_data_next = 32'd0;
    case (axi_araddr)
      4'h0:    if (!empty) rd_data_next = {1'b1, 17'b0, mem[rd_ptr]};
      4'h4:    rd_data_next = {8'b0, drop_cnt, 5'b0, overflow, full, empty,
                               3'b0, count5};
      4'h8:    rd_data_next = {24'b0, threshold, 3'b0, irq_en};
      default: rd_data_next = 32'd0;
    endcase
  end

  // Registered read response, valid for one cycle per request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= 32'd0;
    end else begin
      axi_rvalid <= axi_arvalid;
      if (axi_arvalid) axi_rdata <= rd_data_next;
    end
  end

  // Registered interrupt level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= irq_en & ((count5 >= {1'b0, threshold}) | overflow);
  end

endmodule

// File: tb/tb_inference_result_logger.sv
// tb_inference_result_logger
//   Self-checking bench for inference_result_logger. A queue-based model
//   predicts rvalid/rdata/irq every cycle; directed scenarios also pin the
//   model and DUT to hand-computed literal values, followed by random traffic.

module tb_inference_result_logger;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  predicted_class = 4'd0;
  logic        inference_done = 1'b0;
  logic        mode_select = 1'b0;
  logic        noise_applied = 1'b0;
  logic [3:0]  axi_awaddr = 4'd0;
  logic        axi_awvalid = 1'b0;
  logic [31:0] axi_wdata = 32'd0;
  logic        axi_wvalid = 1'b0;
  logic [3:0]  axi_araddr = 4'd0;
  logic        axi_arvalid = 1'b0;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        irq;

  inference_result_logger #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .predicted_class(predicted_class),
    .inference_done(inference_done),
    .mode_select(mode_select),
    .noise_applied(noise_applied),
    .axi_awaddr(axi_awaddr),
    .axi_awvalid(axi_awvalid),
    .axi_wdata(axi_wdata),
    .axi_wvalid(axi_wvalid),
    .axi_araddr(axi_araddr),
    .axi_arvalid(axi_arvalid),
    .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid),
    .irq(irq)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: the FIFO is just a queue of result words.
  logic [13:0] mq[$];
  int          m_seq = 0;
  bit          m_prev_done = 1'b0;
  bit          m_pend_v = 1'b0;
  logic [13:0] m_pend = 14'd0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  bit          m_irq_en = 1'b0;
  int          m_thr = 1;
  bit          exp_rvalid = 1'b0;
  bit          exp_irq = 1'b0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_seq       = 0;
    m_prev_done = 1'b0;
    m_pend_v    = 1'b0;
    m_pend      = 14'd0;
    m_ovf       = 1'b0;
    m_drop      = 0;
    m_irq_en    = 1'b0;
    m_thr       = 1;
    exp_rvalid  = 1'b0;
    exp_irq     = 1'b0;
    exp_rdata   = 32'd0;
  endtask

  // One clock edge of the model: responses and irq come from the state
  // before the edge, then the edge's clear/flush/pop/push/ctrl effects apply.
  task automatic modelStep();
    int  sz;
    bit  wr;
    bit  is_flush;
    if (!resetn) begin
      modelReset();
      return;
    end
    sz = mq.size();
    exp_irq    = m_irq_en && ((sz >= m_thr) || m_ovf);
    exp_rvalid = axi_arvalid;
    if (axi_arvalid) begin
      case (axi_araddr)
        4'h0:    exp_rdata = (sz > 0) ? (32'h8000_0000 | 32'(mq[0])) : 32'd0;
        4'h4:    exp_rdata = 32'(sz) | (32'(sz == 0) << 8) |
                             (32'(sz == DEPTH) << 9) | (32'(m_ovf) << 10) |
                             (32'(m_drop) << 16);
        4'h8:    exp_rdata = (32'(m_thr) << 4) | 32'(m_irq_en);
        default: exp_rdata = 32'd0;
      endcase
    end
    wr = axi_awvalid && axi_wvalid;
    is_flush = wr && (axi_awaddr == 4'hC) && axi_wdata[0];
    if (wr && (axi_awaddr == 4'hC) && axi_wdata[1]) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (is_flush) begin
      mq.delete();
    end else begin
      if (axi_arvalid && (axi_araddr == 4'h0) && (sz > 0)) mq.delete(0);
      if (m_pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (wr && (axi_awaddr == 4'h8)) begin
      m_irq_en = axi_wdata[0];
      m_thr    = (axi_wdata[7:4] == 4'h0) ? 1 : int'(axi_wdata[7:4]);
    end
    m_pend_v = inference_done && !m_prev_done;
    m_prev_done = inference_done;
    if (m_pend_v) begin
      m_pend = {8'(m_seq), mode_select, noise_applied, predicted_class};
      m_seq  = (m_seq + 1) % 256;
    end
  endtask

  // Model follows every clock edge and every reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      modelStep();
    end
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_rvalid", 32'(axi_rvalid), 32'(exp_rvalid));
      checkOutput("cmp_irq", 32'(irq), 32'(exp_irq));
      if (exp_rvalid || !resetn) checkOutput("cmp_rdata", axi_rdata, exp_rdata);
    end
  end

  // Drive one cycle's worth of inputs just after a falling edge.
  task automatic applyStimulus(input bit done, input bit [3:0] cls,
                               input bit mode, input bit noise,
                               input bit arv, input bit [3:0] ar,
                               input bit wv, input bit [3:0] aw,
                               input bit [31:0] wd);
    @(negedge clk);
    inference_done  = done;
    predicted_class = cls;
    mode_select     = mode;
    noise_applied   = noise;
    axi_arvalid     = arv;
    axi_araddr      = ar;
    axi_awvalid     = wv;
    axi_wvalid      = wv;
    axi_awaddr      = aw;
    axi_wdata       = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic pulse(input bit [3:0] cls, input bit mode, input bit noise);
    applyStimulus(1'b1, cls, mode, noise, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b0, cls, mode, noise, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic axiWrite(input bit [3:0] aw, input bit [31:0] wd);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, aw, wd);
  endtask

  task automatic axiRead(input bit [3:0] ar, output logic [31:0] data);
    bit got = 1'b0;
    data = 32'd0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, ar, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 4 && !got; i++) begin
      idle(1);
      if (axi_rvalid === 1'b1) begin
        got  = 1'b1;
        data = axi_rdata;
      end
    end
    if (!got) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL rd_timeout addr=0x%0h actual=no_rvalid required=rvalid", ar);
    end
  endtask

  task automatic doReset();
    idle(1);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    bit [3:0]    ar;
    bit [3:0]    aw;
    bit [31:0]   wd;
    int          r;

    // Reset state and register defaults.
    doReset();
    checkOutput("rst_rvalid", 32'(axi_rvalid), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    axiRead(4'h4, rd); checkOutput("rst_status", rd, 32'h0000_0100);
    axiRead(4'h8, rd); checkOutput("rst_ctrl", rd, 32'h0000_0010);
    axiRead(4'hC, rd); checkOutput("clear_reads0", rd, 32'h0000_0000);
    axiWrite(4'h8, 32'h0000_0005);
    axiWrite(4'h2, 32'hFFFF_FFFF);
    axiRead(4'h8, rd); checkOutput("thr0_as_1", rd, 32'h0000_0011);
    axiRead(4'h2, rd); checkOutput("unmapped", rd, 32'h0000_0000);

    // Single capture: entry layout {seq,mode,noise,class} gives 0x37 for
    // seq 0, mode 1, noise 1, class 7.
    doReset();
    pulse(4'd7, 1'b1, 1'b1);
    idle(2);
    axiRead(4'h0, rd); checkOutput("single_pop", rd, 32'h8000_0037);
    axiRead(4'h4, rd); checkOutput("single_empty", rd, 32'h0000_0100);
    axiRead(4'h0, rd); checkOutput("pop_empty", rd, 32'h0000_0000);

    // Level hold: one entry only; the next event carries seq 1.
    doReset();
    repeat (20) applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    idle(2);
    axiRead(4'h4, rd); checkOutput("hold_count1", rd, 32'h0000_0001);
    axiRead(4'h0, rd); checkOutput("hold_entry", rd, 32'h8000_0003);
    pulse(4'd0, 1'b0, 1'b0);
    idle(2);
    axiRead(4'h0, rd); checkOutput("hold_next_seq1", rd, 32'h8000_0040);

    // Overflow: ten events into eight slots.
    doReset();
    for (int i = 0; i < 10; i++) pulse(4'(i), 1'b0, 1'b0);
    idle(2);
    axiRead(4'h4, rd); checkOutput("ovf_status", rd, 32'h0002_0608);
    for (int i = 0; i < 8; i++) begin
      axiRead(4'h0, rd);
      checkOutput($sformatf("ovf_pop%0d", i), rd,
                  32'h8000_0000 | (32'(i) << 6) | 32'(i));
    end
    axiRead(4'h4, rd); checkOutput("ovf_sticky", rd, 32'h0002_0500);
    axiWrite(4'hC, 32'h0000_0002);
    axiRead(4'h4, rd); checkOutput("ovf_cleared", rd, 32'h0000_0100);

    // Interrupt at threshold 3, falling after one pop.
    doReset();
    axiWrite(4'h8, 32'h0000_0031);
    pulse(4'd1, 1'b0, 1'b0);
    pulse(4'd2, 1'b0, 1'b0);
    pulse(4'd3, 1'b0, 1'b0);
    idle(1);
    checkOutput("irq_pre", 32'(irq), 32'd0);
    idle(1);
    checkOutput("irq_rise", 32'(irq), 32'd1);
    axiRead(4'h0, rd); checkOutput("irq_pop", rd, 32'h8000_0001);
    idle(1);
    checkOutput("irq_fall", 32'(irq), 32'd0);

    // Push and pop together while full, then flush against a push, then
    // push into an empty FIFO against a POP read.
    doReset();
    for (int i = 0; i < 8; i++) pulse(4'd5, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 32'd0);
    idle(1);
    checkOutput("pp_rvalid", 32'(axi_rvalid), 32'd1);
    checkOutput("pp_rdata", axi_rdata, 32'h8000_0005);
    axiRead(4'h4, rd); checkOutput("pp_status", rd, 32'h0000_0208);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'hC, 32'd1);
    idle(1);
    axiRead(4'h4, rd); checkOutput("flush_status", rd, 32'h0000_0100);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 32'd0);
    idle(1);
    checkOutput("nobypass_rdata", axi_rdata, 32'h0000_0000);
    axiRead(4'h0, rd); checkOutput("seq_after_flush", rd, 32'h8000_0285);

    // Reset in the middle of traffic with a read and a push in flight.
    doReset();
    axiWrite(4'h8, 32'h0000_0011);
    for (int i = 0; i < 5; i++) pulse(4'd9, 1'b0, 1'b1);
    idle(2);
    checkOutput("mid_irq_high", 32'(irq), 32'd1);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 4'd0, 32'd0);
    @(posedge clk);
    #2;
    resetn         = 1'b0;
    inference_done = 1'b0;
    axi_arvalid    = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", 32'(axi_rvalid), 32'd0);
    checkOutput("mid_rst_rdata", axi_rdata, 32'd0);
    checkOutput("mid_rst_irq", 32'(irq), 32'd0);
    idle(2);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("post_rst_rvalid", 32'(axi_rvalid), 32'd0);
    end
    axiRead(4'h4, rd); checkOutput("post_rst_status", rd, 32'h0000_0100);
    axiRead(4'h8, rd); checkOutput("post_rst_ctrl", rd, 32'h0000_0010);
    pulse(4'd2, 1'b0, 1'b0);
    idle(2);
    axiRead(4'h0, rd); checkOutput("post_rst_seq0", rd, 32'h8000_0002);

    // Random traffic checked by the compare process against the model.
    for (int c = 0; c < 2500; c++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 6))
        0, 1, 2: ar = 4'h0;
        3:       ar = 4'h4;
        4:       ar = 4'h8;
        5:       ar = 4'hC;
        default: ar = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0, 1:    aw = 4'h8;
        2:       aw = 4'hC;
        default: aw = 4'($urandom_range(0, 15));
      endcase
      wd = $urandom;
      if (aw == 4'hC && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (r < 25) || (r >= 95), ar,
                    (r >= 25 && r < 33) || (r >= 97), aw, wd);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
